rf_write_arbiter: RTL and testbench



---
 rtl/rf_write_arbiter_pkg.sv | 49 ++++
 rtl/rf_write_arbiter_rr_arb3.sv | 59 +++++
 rtl/rf_write_arbiter.sv | 110 +++++++++++
 tb/tb_rf_write_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_pkg
// Shared definitions for the register-file write-port arbiter.
//   NUM_REQ  : number of result producers sharing the write port
//   X0_IDX   : index of the hard-wired zero register (writes are dropped)
//   sel_e    : grant-select encoding driven on o_grant_sel
//   rr_pick  : round-robin pick of the first valid requester from a start
// ---------------------------------------------------------------------------
package rf_write_arbiter_pkg;

    localparam int NUM_REQ = 3;
    localparam int X0_IDX  = 0;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_LOAD = 2'b01,
        SEL_CSR  = 2'b10,
        SEL_NONE = 2'b11
    } sel_e;

    // Search order is start, start+1, start+2 (mod 3); the first valid
    // requester wins. A start of 3 can never be produced by the pointer
    // logic, but if it ever shows up it falls into the default arm and is
    // treated exactly like 0.
    function automatic sel_e rr_pick(input logic [NUM_REQ-1:0] valid,
                                     input logic [1:0]         start);
        sel_e pick;
        pick = SEL_NONE;
        case (start)
            2'd1: begin
                if      (valid[1]) pick = SEL_LOAD;
                else if (valid[2]) pick = SEL_CSR;
                else if (valid[0]) pick = SEL_ALU;
            end
            2'd2: begin
                if      (valid[2]) pick = SEL_CSR;
                else if (valid[0]) pick = SEL_ALU;
                else if (valid[1]) pick = SEL_LOAD;
            end
            default: begin
                if      (valid[0]) pick = SEL_ALU;
                else if (valid[1]) pick = SEL_LOAD;
                else if (valid[2]) pick = SEL_CSR;
            end
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_arb3.sv
// ---------------------------------------------------------------------------
// rr_arb3
// Three-way round-robin arbiter: priority pointer register plus the
// combinational pick. No grant is produced while stalled or in reset.
// Ports:
//   i_clk    : rising-edge clock
//   i_rst    : synchronous active-high reset (pointer -> 0, grants masked)
//   i_stall  : suppress all grants this cycle
//   i_valid  : per-requester request valid
//   o_grant  : one-hot grant (or zero)
//   o_idx    : encoded winner, SEL_NONE when nobody wins
// ---------------------------------------------------------------------------
module rr_arb3
    import rf_write_arbiter_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_stall,
    input  logic [NUM_REQ-1:0] i_valid,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [1:0]         o_idx
);

    logic [1:0] r_ptr;
    sel_e       w_idx;

    // Pick the winner for this cycle. Reset and stall both force "no
    // winner" so that ready stays low and the pointer does not move.
    always_comb begin
        w_idx = SEL_NONE;
        if (!i_rst && !i_stall) begin
            w_idx = rr_pick(i_valid, r_ptr);
        end
    end

    // Expand the encoded winner into the one-hot ready vector.
    always_comb begin
        o_grant = '0;
        case (w_idx)
            SEL_ALU:  o_grant = 3'b001;
            SEL_LOAD: o_grant = 3'b010;
            SEL_CSR:  o_grant = 3'b100;
            default:  o_grant = 3'b000;
        endcase
    end

    assign o_idx = w_idx;

    // After a grant the requester just served drops to lowest priority by
    // moving the pointer one past it; with no grant the pointer holds.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 2'd0;
        end else if (w_idx != SEL_NONE) begin
            r_ptr <= (w_idx == SEL_CSR) ? 2'd0 : (2'(w_idx) + 2'd1);
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Shares the single register-file write port among ALU (0), load unit (1)
// and CSR/mul-div (2) using round-robin arbitration, and registers the
// winning address/data onto the write port one cycle after acceptance.
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_stall                 : freeze arbitration (no grants)
//   i_req_valid/o_req_ready : per-requester valid/ready handshake
//   i_req_addrN/i_req_dataN : destination and data for requester N
//   o_grant_sel             : registered winner code, 2'b11 when none
//   o_wr_en/o_wr_addr/o_wr_data : register-file write port
// ---------------------------------------------------------------------------
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    output logic [NUM_REQ-1:0]    o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr0,
    input  logic [ADDR_WIDTH-1:0] i_req_addr1,
    input  logic [ADDR_WIDTH-1:0] i_req_addr2,
    input  logic [DATA_WIDTH-1:0] i_req_data0,
    input  logic [DATA_WIDTH-1:0] i_req_data1,
    input  logic [DATA_WIDTH-1:0] i_req_data2,
    output logic [1:0]            o_grant_sel,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data
);

    logic [NUM_REQ-1:0]    w_grant;
    logic [1:0]            w_idx;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_accept;

    logic [1:0]            r_grant_sel;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    rr_arb3 u_rr_arb3 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_stall (i_stall),
        .i_valid (i_req_valid),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign o_req_ready = w_grant;
    assign w_accept    = (w_idx != SEL_NONE);

    // 3:1 write-data select keyed by the encoded winner.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        case (w_idx)
            SEL_ALU: begin
                w_sel_addr = i_req_addr0;
                w_sel_data = i_req_data0;
            end
            SEL_LOAD: begin
                w_sel_addr = i_req_addr1;
                w_sel_data = i_req_data1;
            end
            SEL_CSR: begin
                w_sel_addr = i_req_addr2;
                w_sel_data = i_req_data2;
            end
            default: begin
                w_sel_addr = '0;
                w_sel_data = '0;
            end
        endcase
    end

    // Write-port registers. A write to x0 is still accepted (and still
    // consumes a round-robin turn) but never asserts the write enable.
    // With no transfer, address and data keep their last values so the
    // register file inputs do not toggle needlessly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant_sel <= SEL_NONE;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else if (w_accept) begin
            r_grant_sel <= w_idx;
            r_wr_en     <= (w_sel_addr != ADDR_WIDTH'(X0_IDX));
            r_wr_addr   <= w_sel_addr;
            r_wr_data   <= w_sel_data;
        end else begin
            r_grant_sel <= SEL_NONE;
            r_wr_en     <= 1'b0;
        end
    end

    assign o_grant_sel = r_grant_sel;
    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
// Self-checking bench: directed scenarios followed by randomized traffic.
// A reference model predicts each grant and pushes the expected write into
// a scoreboard; an independent monitor pops and compares whenever the DUT
// presents a registered grant.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic [2:0]    reqValid;
    logic [AW-1:0] reqAddr [3];
    logic [DW-1:0] reqData [3];

    logic [2:0]    o_req_ready;
    logic [1:0]    o_grant_sel;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [DW-1:0] o_wr_data;

    typedef struct {
        int            due;
        logic [1:0]    sel;
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   errors   = 0;
    int   checks   = 0;
    int   modelPtr = 0;
    bit   monOn    = 1'b0;

    rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_stall     (stall),
        .i_req_valid (reqValid),
        .o_req_ready (o_req_ready),
        .i_req_addr0 (reqAddr[0]),
        .i_req_addr1 (reqAddr[1]),
        .i_req_addr2 (reqAddr[2]),
        .i_req_data0 (reqData[0]),
        .i_req_data1 (reqData[1]),
        .i_req_data2 (reqData[2]),
        .o_grant_sel (o_grant_sel),
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter used to timestamp expected writes.
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // Reference pick: walk requesters starting at the pointer, first valid wins.
    function automatic int modelPick(input logic [2:0] v, input int p);
        for (int k = 0; k < 3; k++) begin
            int c;
            c = (p + k) % 3;
            if (v[c[1:0]]) return c;
        end
        return -1;
    endfunction

    // Drive stall/rst for one cycle, check ready against the model mid-cycle,
    // queue the expected write, and return just after the next rising edge.
    task automatic applyStimulus(input logic st, input logic rs, output int acc);
        exp_t       e;
        int         pick;
        logic [2:0] expReady;
        stall = st;
        rst   = rs;
        @(negedge clk);
        acc      = -1;
        expReady = 3'b000;
        if (rs) begin
            modelPtr = 0;
        end else if (!st) begin
            pick = modelPick(reqValid, modelPtr);
            if (pick >= 0) begin
                acc = pick;
                expReady[pick[1:0]] = 1'b1;
                e.due  = cyc + 1;
                e.sel  = pick[1:0];
                e.addr = reqAddr[pick];
                e.data = reqData[pick];
                e.en   = (reqAddr[pick] != 0);
                sb.push_back(e);
                modelPtr = (pick + 1) % 3;
            end
        end
        checkOutput("req_ready", o_req_ready, expReady);
        @(posedge clk);
        #1;
    endtask

    // Monitor: whenever a grant is presented, pop the oldest expectation and
    // compare; otherwise the write enable must be low.
    always @(negedge clk) begin
        exp_t e;
        if (monOn) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL missing_write cyc=%0d got=none exp=due%0d", cyc, sb[0].due);
                void'(sb.pop_front());
            end
            if (o_grant_sel !== 2'b11) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write cyc=%0d got=sel%0b exp=none", cyc, o_grant_sel);
                end else begin
                    e = sb.pop_front();
                    checkOutput("write_cycle", cyc, e.due);
                    checkOutput("grant_sel", o_grant_sel, e.sel);
                    checkOutput("wr_en", o_wr_en, e.en);
                    checkOutput("wr_addr", o_wr_addr, e.addr);
                    checkOutput("wr_data", o_wr_data, e.data);
                end
            end else begin
                checkOutput("idle_wr_en", o_wr_en, 1'b0);
            end
        end
    end

    task automatic setAllValid();
        reqValid   = 3'b111;
        reqAddr[0] = 5'd3;  reqData[0] = 32'hA0A0_0003;
        reqAddr[1] = 5'd4;  reqData[1] = 32'hB1B1_0004;
        reqAddr[2] = 5'd5;  reqData[2] = 32'hC2C2_0005;
    endtask

    task automatic newReq(input int i);
        reqValid[i] = 1'b1;
        reqAddr[i]  = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
        reqData[i]  = $urandom;
    endtask

    // Main stimulus sequence.
    initial begin
        int acc;
        rst      = 1'b1;
        stall    = 1'b0;
        reqValid = 3'b000;
        for (int i = 0; i < 3; i++) begin
            reqAddr[i] = '0;
            reqData[i] = '0;
        end

        // Reset for two cycles, then idle.
        applyStimulus(1'b0, 1'b1, acc);
        applyStimulus(1'b0, 1'b1, acc);
        monOn = 1'b1;
        checkOutput("rst_wr_en", o_wr_en, 1'b0);
        checkOutput("rst_grant_sel", o_grant_sel, 2'b11);
        checkOutput("rst_wr_addr", o_wr_addr, 0);
        checkOutput("rst_wr_data", o_wr_data, 0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, acc);

        // Single requester 1.
        reqValid   = 3'b010;
        reqAddr[1] = 5'd7;
        reqData[1] = 32'hDEADBEEF;
        applyStimulus(1'b0, 1'b0, acc);
        reqValid = 3'b000;
        checkOutput("single_wr_en", o_wr_en, 1'b1);
        checkOutput("single_wr_addr", o_wr_addr, 7);
        checkOutput("single_wr_data", o_wr_data, 32'hDEADBEEF);
        checkOutput("single_grant_sel", o_grant_sel, 2'b01);
        applyStimulus(1'b0, 1'b0, acc);

        // All valid straight out of reset: strict rotation 0,1,2,0,1,2.
        setAllValid();
        applyStimulus(1'b0, 1'b1, acc);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, acc);
            checkOutput("rr_order", acc, k % 3);
        end
        reqValid = 3'b000;
        applyStimulus(1'b0, 1'b0, acc);

        // x0 suppression: move pointer to 1, then requester 2 writes x0.
        reqValid = 3'b001;
        applyStimulus(1'b0, 1'b0, acc);
        reqValid   = 3'b100;
        reqAddr[2] = 5'd0;
        reqData[2] = 32'h0000_1234;
        applyStimulus(1'b0, 1'b0, acc);
        checkOutput("x0_accept", acc, 2);
        checkOutput("x0_wr_en", o_wr_en, 1'b0);
        checkOutput("x0_grant_sel", o_grant_sel, 2'b10);
        setAllValid();
        applyStimulus(1'b0, 1'b0, acc);
        checkOutput("x0_ptr_advance", acc, 0);

        // Stall for three cycles with everyone valid; pointer must hold at 1.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, acc);
            checkOutput("stall_no_grant", acc, -1);
        end
        checkOutput("stall_wr_en", o_wr_en, 1'b0);
        applyStimulus(1'b0, 1'b0, acc);
        checkOutput("post_stall_grant", acc, 1);

        // Reset in the middle of a stream.
        applyStimulus(1'b0, 1'b1, acc);
        applyStimulus(1'b0, 1'b0, acc);
        checkOutput("mid_first", acc, 0);
        applyStimulus(1'b0, 1'b0, acc);
        checkOutput("mid_second", acc, 1);
        applyStimulus(1'b0, 1'b1, acc);
        checkOutput("mid_rst_wr_en", o_wr_en, 1'b0);
        checkOutput("mid_rst_grant_sel", o_grant_sel, 2'b11);
        checkOutput("mid_rst_wr_addr", o_wr_addr, 0);
        checkOutput("mid_rst_wr_data", o_wr_data, 0);
        applyStimulus(1'b0, 1'b0, acc);
        checkOutput("mid_post_rst_grant", acc, 0);

        // Randomized traffic with occasional stalls, resets and dropped requests.
        reqValid = 3'b000;
        for (int n = 0; n < 400; n++) begin
            logic st;
            logic rs;
            st = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 49) == 0);
            applyStimulus(st, rs, acc);
            for (int i = 0; i < 3; i++) begin
                if (acc == i) reqValid[i] = 1'b0;
                if (!reqValid[i]) begin
                    if ($urandom_range(0, 9) < 5) newReq(i);
                end else if ($urandom_range(0, 19) == 0) begin
                    reqValid[i] = 1'b0;
                end
            end
        end

        // Drain and confirm every expected write was observed.
        reqValid = 3'b000;
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, acc);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
